// File: rtl/mul_pipe_ctrl.sv
// Sequencing controller for the multi-cycle multiply pipe: per-stage valid/dst
// tracking, common advance enable, writeback arbitration against the ALU path
// with a starvation guard, and RAW hazard detection for decode.

// Single-stage RAW compare; register 0 never hazards.
module mul_haz_cmp #(
  parameter int DST_W = 5
) (
  input  logic             v,
  input  logic [DST_W-1:0] dst,
  input  logic [DST_W-1:0] src_a,
  input  logic [DST_W-1:0] src_b,
  output logic             hit
);
  assign hit = v && (((src_a == dst) && (src_a != '0)) ||
                     ((src_b == dst) && (src_b != '0)));
endmodule

module mul_pipe_ctrl #(
  parameter int STAGES     = 5,
  parameter int DST_W      = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [DST_W-1:0]  issue_dst,
  output logic              issue_ready,
  input  logic [DST_W-1:0]  src_a,
  input  logic [DST_W-1:0]  src_b,
  output logic              raw_hazard,
  input  logic              alu_wb_valid,
  output logic              alu_stall,
  output logic              stage_adv,
  output logic [STAGES-1:0] stage_valid,
  output logic              wb_valid,
  output logic [DST_W-1:0]  wb_dst,
  output logic              busy
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][DST_W-1:0] dst_q, dst_d;
  logic [CW-1:0]                sc_q, sc_d;
  logic [STAGES-1:0]            hit;
  logic                         last_v, mul_grant;

  // Writeback arbitration and the shared advance enable; the pipe freezes only
  // when the last stage holds a result that lost to the ALU.
  always_comb begin
    last_v      = vld_q[STAGES-1];
    mul_grant   = last_v && (!alu_wb_valid || (sc_q == CW'(STARVE_MAX)));
    wb_valid    = mul_grant;
    wb_dst      = dst_q[STAGES-1];
    alu_stall   = alu_wb_valid && mul_grant;
    stage_adv   = !last_v || mul_grant;
    issue_ready = stage_adv && !flush;
    stage_valid = vld_q;
    busy        = |vld_q;
  end

  // Per-stage hazard compares against in-flight destinations only.
  for (genvar i = 0; i < STAGES; i++) begin : g_haz
    mul_haz_cmp #(.DST_W(DST_W)) u_cmp (
      .v    (vld_q[i]),
      .dst  (dst_q[i]),
      .src_a(src_a),
      .src_b(src_b),
      .hit  (hit[i])
    );
  end
  assign raw_hazard = |hit;

  // Next stage state: flush squashes valids, advance shifts, freeze holds.
  // Starvation counter saturates naturally because reaching STARVE_MAX grants.
  always_comb begin
    vld_d = vld_q;
    dst_d = dst_q;
    sc_d  = '0;
    if (flush) begin
      vld_d = '0;
    end else begin
      if (stage_adv) begin
        vld_d = {vld_q[STAGES-2:0], issue_valid && issue_ready};
        dst_d = {dst_q[STAGES-2:0], issue_dst};
      end
      if (last_v && alu_wb_valid && !mul_grant) sc_d = sc_q + CW'(1);
    end
  end

  // State registers with synchronous reset dominating flush and issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      dst_q <= '0;
      sc_q  <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
      sc_q  <= sc_d;
    end
  end
endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Self-checking bench for mul_pipe_ctrl: per-cycle reference model of the
// control outputs, a writeback scoreboard of destinations, and directed
// latency / starvation / flush / hazard / reset scenarios plus random traffic.
module tb_mul_pipe_ctrl;
  localparam int S  = 5;
  localparam int DW = 5;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          reset, flush, issue_valid, alu_wb_valid;
  logic [DW-1:0] issue_dst, src_a, src_b, wb_dst;
  logic          issue_ready, raw_hazard, alu_stall, stage_adv, wb_valid, busy;
  logic [S-1:0]  stage_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mul_pipe_ctrl #(.STAGES(S), .DST_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready),
    .src_a(src_a), .src_b(src_b), .raw_hazard(raw_hazard),
    .alu_wb_valid(alu_wb_valid), .alu_stall(alu_stall), .stage_adv(stage_adv),
    .stage_valid(stage_valid), .wb_valid(wb_valid), .wb_dst(wb_dst), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state and writeback scoreboard.
  logic          m_v [S];
  logic [DW-1:0] m_d [S];
  int            m_sc;
  logic [DW-1:0] sb_q[$];

  initial begin
    for (int i = 0; i < S; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
    m_sc = 0;
  end

  // Compare DUT outputs to the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    logic last, grant, adv, rdy, haz, bsy;
    logic [S-1:0] sv;
    last  = m_v[S-1];
    grant = last && (!alu_wb_valid || m_sc == SM);
    adv   = !last || grant;
    rdy   = adv && !flush;
    haz   = 1'b0;
    bsy   = 1'b0;
    for (int i = 0; i < S; i++) begin
      sv[i] = m_v[i];
      bsy   = bsy | m_v[i];
      if (m_v[i] && ((src_a == m_d[i] && src_a != 0) || (src_b == m_d[i] && src_b != 0)))
        haz = 1'b1;
    end
    chk("ctl{rdy,adv,wb,stall,busy,haz}",
        {26'd0, issue_ready, stage_adv, wb_valid, alu_stall, busy, raw_hazard},
        {26'd0, rdy, adv, grant, alu_wb_valid && grant, bsy, haz});
    chk("stage_valid", {{(32-S){1'b0}}, stage_valid}, {{(32-S){1'b0}}, sv});
    if (wb_valid) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 32'(wb_dst), 32'hdead);
      else chk("wb_dst", 32'(wb_dst), 32'(sb_q.pop_front()));
    end
    if (reset) begin
      for (int i = 0; i < S; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
      m_sc = 0;
      sb_q.delete();
    end else if (flush) begin
      for (int i = 0; i < S; i++) m_v[i] = 1'b0;
      m_sc = 0;
      sb_q.delete();
    end else begin
      if (adv) begin
        for (int i = S-1; i > 0; i--) begin m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; end
        m_v[0] = issue_valid && rdy;
        m_d[0] = issue_dst;
        if (issue_valid && rdy) sb_q.push_back(issue_dst);
      end
      m_sc = (last && alu_wb_valid && !grant) ? m_sc + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  // Issue one op, then count cycles until its writeback.
  task automatic lat_check(input string tag, input logic [DW-1:0] d);
    int t0, lat;
    lat = -1;
    issue_valid = 1'b1; issue_dst = d;
    @(negedge clk); t0 = cyc;
    tick(); issue_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wb_valid) begin lat = cyc - t0; break; end
    end
    chk(tag, 32'(lat), 32'(S));
    chk({tag, "_dst"}, 32'(wb_dst), 32'(d));
    tick(); @(negedge clk);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lost;
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_dst = '0;
    src_a = '0; src_b = '0; alu_wb_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outs", {26'd0, issue_ready, stage_adv, wb_valid, alu_stall, busy, raw_hazard},
        32'b110000);
    tick();

    // Single op latency.
    lat_check("lat_single", 5'd7);

    // Back-to-back issue.
    for (int i = 1; i <= 5; i++) begin
      issue_valid = 1'b1; issue_dst = DW'(i);
      @(negedge clk); chk("b2b_rdy", 32'(issue_ready), 32'd1);
      tick();
    end
    idle();
    repeat (S + 3) tick();

    // Writeback conflict: ALU wins STARVE_MAX times, then the multiply is forced.
    alu_wb_valid = 1'b1;
    issue_valid = 1'b1; issue_dst = 5'd9;
    tick(); idle();
    lost = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (stage_valid[S-1] && !wb_valid) lost++;
      if (wb_valid) begin
        chk("starve_dst", 32'(wb_dst), 32'd9);
        chk("starve_stall", 32'(alu_stall), 32'd1);
        break;
      end
      tick();
    end
    chk("starve_lost", 32'(lost), 32'(SM));
    tick(); alu_wb_valid = 1'b0;
    repeat (3) tick();

    // Flush with dst 4 in M3, dst 6 in M2, and a same-cycle issue.
    issue_valid = 1'b1; issue_dst = 5'd4; tick();
    issue_dst = 5'd6; tick();
    issue_valid = 1'b0; tick();
    flush = 1'b1; issue_valid = 1'b1; issue_dst = 5'd11;
    @(negedge clk); chk("flush_rdy", 32'(issue_ready), 32'd0);
    tick(); idle();
    @(negedge clk); chk("flush_sv", 32'(stage_valid), 32'd0);
    repeat (S + 2) tick();

    // RAW hazards.
    issue_valid = 1'b1; issue_dst = 5'd12; tick();
    issue_dst = 5'd0; tick();
    idle(); src_a = 5'd12;
    @(negedge clk); chk("haz_m2", 32'(raw_hazard), 32'd1);
    tick(); src_a = 5'd0; src_b = 5'd0;
    @(negedge clk); chk("haz_r0", 32'(raw_hazard), 32'd0);
    repeat (S) tick();
    src_b = 5'd12;
    @(negedge clk); chk("haz_after_wb", 32'(raw_hazard), 32'd0);
    tick(); src_b = 5'd0;

    // Reset mid-operation with three ops in flight and starve count at 2.
    alu_wb_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin issue_valid = 1'b1; issue_dst = DW'(20 + i); tick(); end
    idle();
    lost = 0;
    for (int k = 0; k < 30 && lost < 2; k++) begin
      @(negedge clk);
      if (stage_valid[S-1] && !wb_valid) lost++;
      tick();
    end
    chk("pre_rst_lost", 32'(lost), 32'd2);
    reset = 1'b1; tick();
    reset = 1'b0; alu_wb_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {26'd0, issue_ready, stage_adv, wb_valid, alu_stall, busy, raw_hazard},
        32'b110000);
    chk("rst_mid_sv", 32'(stage_valid), 32'd0);
    tick();
    lat_check("lat_after_rst", 5'd17);

    // Random traffic against the model and scoreboard.
    for (int k = 0; k < 400; k++) begin
      issue_valid  = ($urandom_range(0, 3) != 0);
      issue_dst    = DW'($urandom_range(0, 7));
      alu_wb_valid = ($urandom_range(0, 1) == 1);
      flush        = ($urandom_range(0, 24) == 0);
      src_a        = DW'($urandom_range(0, 7));
      src_b        = DW'($urandom_range(0, 7));
      tick();
    end
    idle(); alu_wb_valid = 1'b0;
    repeat (S + 4) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
